clk_div_ctrl: RTL and testbench

- Run-time programmable clock-divider controller. Divides clk by N, where N is configurable with a valid/ready handshake.
- Produces a registered divided clock plus single-cycle rise/fall clock-enable strobes, so downstream logic can stay in the clk domain.
- Applies ratio changes and stop requests only at period boundaries, so no output period is ever truncated.
- Keeps a wrapping period counter, the successor to the fixed divide-by-4 path.

---
 rtl/clk_div_ctrl.sv | 87 ++++++++
 tb/tb_clk_div_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable clock divider with boundary-aligned ratio changes and stops
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4,
  parameter int PCNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              ce_rise,
  output logic              ce_fall,
  output logic              busy,
  output logic [PCNT_W-1:0] period_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, div_q, div_n, pend_q, pend_n, h_n;
  logic [PCNT_W-1:0] pc_n;
  logic pend_v, pend_v_n, clk_n, rise_n, fall_n, err_n, wrap, xfer, legal, run_n;
  assign cfg_ready = !pend_v;
  assign busy = state != IDLE;
  // next state, counter, ratio bookkeeping and registered-output values from next cnt/N
  always_comb begin
    xfer = cfg_valid && !pend_v;
    legal = cfg_div > CNT_W'(1);
    wrap = state != IDLE && cnt == div_q - 1'b1;
    state_n = state;
    cnt_n = '0;
    div_n = div_q;
    pend_n = pend_q;
    pend_v_n = pend_v;
    pc_n = period_cnt;
    err_n = xfer && !legal;
    if (state == IDLE) begin
      div_n = xfer && legal ? cfg_div : div_q;
      state_n = run_en ? RUN : IDLE;
    end else begin
      cnt_n = wrap ? '0 : cnt + 1'b1;
      if (xfer && legal) begin
        pend_n = cfg_div;
        pend_v_n = 1'b1;
      end
      if (wrap) begin
        pc_n = period_cnt + 1'b1;
        div_n = pend_v ? pend_q : div_q;
        pend_v_n = pend_v ? 1'b0 : pend_v_n;
      end
      state_n = run_en ? RUN : (state == RUN || !wrap) ? STOP_PEND : IDLE;
    end
    h_n = div_n - (div_n >> 1);
    run_n = state_n != IDLE;
    clk_n = run_n && cnt_n < h_n;
    rise_n = run_n && cnt_n == '0;
    fall_n = run_n && cnt_n == h_n;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      div_q <= CNT_W'(DEF_DIV);
      pend_q <= '0;
      pend_v <= 1'b0;
      clk_out <= 1'b0;
      ce_rise <= 1'b0;
      ce_fall <= 1'b0;
      cfg_err <= 1'b0;
      period_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div_q <= div_n;
      pend_q <= pend_n;
      pend_v <= pend_v_n;
      clk_out <= clk_n;
      ce_rise <= rise_n;
      ce_fall <= fall_n;
      cfg_err <= err_n;
      period_cnt <= pc_n;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;
  logic clk = 0, rst = 1, run_en = 0, cfg_valid = 0;
  logic [7:0] cfg_div = 0;
  logic cfg_ready, cfg_err, clk_out, ce_rise, ce_fall, busy;
  logic [1:0] period_cnt;
  int checks = 0, failures = 0;

  clk_div_ctrl dut (
    .clk(clk), .rst(rst), .run_en(run_en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .ce_rise(ce_rise),
    .ce_fall(ce_fall), .busy(busy), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [2:0] e);
    tick();
    chk(tag, {29'd0, clk_out, ce_rise, ce_fall}, {29'd0, e});
  endtask

  initial begin
    tick();
    tick();
    chk("rst_outs", {clk_out, ce_rise, ce_fall, busy, cfg_err}, 5'b0);
    chk("rst_pc", period_cnt, 0);
    chk("rst_ready", cfg_ready, 1);
    rst = 0;
    tick();
    chk("idle_outs", {clk_out, ce_rise, ce_fall, busy}, 4'b0);
    // default N=4 over four periods plus the wrap of period_cnt
    run_en = 1;
    for (int i = 0; i < 17; i++) begin
      st($sformatf("n4_%0d", i), {(i % 4) < 2, (i % 4) == 0, (i % 4) == 2});
      chk($sformatf("n4_pc_%0d", i), period_cnt, (i / 4) % 4);
    end
    chk("n4_busy", busy, 1);
    st("n4_c1", 3'b100);
    // ratio change to 3 at cnt=1, second offer stalls while pending
    chk("ready_before", cfg_ready, 1);
    cfg_valid = 1; cfg_div = 3;
    st("chg_c2", 3'b001);
    chk("chg_ready_c2", cfg_ready, 0);
    cfg_div = 5;
    st("chg_c3", 3'b000);
    chk("chg_ready_c3", cfg_ready, 0);
    st("n3_c0", 3'b110);
    chk("n3_ready", cfg_ready, 1);
    chk("n3_pc", period_cnt, 1);
    st("n3_c1", 3'b100);
    chk("second_accept", cfg_ready, 0);
    cfg_valid = 0;
    st("n3_c2", 3'b001);
    st("n5_c0", 3'b110);
    chk("n5_pc", period_cnt, 2);
    chk("n5_ready", cfg_ready, 1);
    // move to N=6
    cfg_valid = 1; cfg_div = 6;
    st("n5_c1", 3'b100);
    cfg_valid = 0;
    st("n5_c2", 3'b100);
    st("n5_c3", 3'b001);
    st("n5_c4", 3'b000);
    st("n6_c0", 3'b110);
    chk("n6_pc", period_cnt, 3);
    // stop request at cnt=1 completes the period
    st("n6_c1", 3'b100);
    run_en = 0;
    st("stop_c2", 3'b100);
    chk("stop_busy", busy, 1);
    st("stop_c3", 3'b001);
    st("stop_c4", 3'b000);
    st("stop_c5", 3'b000);
    chk("stop_busy5", busy, 1);
    st("stop_idle", 3'b000);
    chk("stop_idle_busy", busy, 0);
    chk("stop_pc", period_cnt, 0);
    st("stop_idle2", 3'b000);
    // restart, then a stop/restart inside one period leaves no gap
    run_en = 1;
    st("re_c0", 3'b110);
    st("re_c1", 3'b100);
    st("re_c2", 3'b100);
    run_en = 0;
    st("re_c3", 3'b001);
    run_en = 1;
    st("re_c4", 3'b000);
    st("re_c5", 3'b000);
    st("re_wrap", 3'b110);
    chk("re_busy", busy, 1);
    chk("re_pc", period_cnt, 1);
    st("re_c1b", 3'b100);
    run_en = 0;
    st("re_s2", 3'b100);
    st("re_s3", 3'b001);
    st("re_s4", 3'b000);
    st("re_s5", 3'b000);
    st("re_idle", 3'b000);
    chk("re_idle_busy", busy, 0);
    chk("re_idle_pc", period_cnt, 2);
    // config in IDLE on the run_en rising edge applies immediately
    cfg_valid = 1; cfg_div = 2; run_en = 1;
    st("n2_c0", 3'b110);
    chk("n2_ready0", cfg_ready, 1);
    cfg_valid = 0;
    st("n2_c1", 3'b001);
    chk("n2_ready1", cfg_ready, 1);
    st("n2_c0b", 3'b110);
    chk("n2_pc", period_cnt, 3);
    st("n2_c1b", 3'b001);
    // illegal ratios while running
    cfg_valid = 1; cfg_div = 0;
    st("err0", 3'b110);
    chk("err0_pulse", cfg_err, 1);
    chk("err0_ready", cfg_ready, 1);
    cfg_div = 1;
    st("err1", 3'b001);
    chk("err1_pulse", cfg_err, 1);
    chk("err1_ready", cfg_ready, 1);
    cfg_valid = 0;
    st("err_done", 3'b110);
    chk("err_clear", cfg_err, 0);
    chk("err_pc", period_cnt, 1);
    st("err_n2", 3'b001);
    // reset mid-run drops a pending ratio
    cfg_valid = 1; cfg_div = 7;
    st("pend_wrap", 3'b110);
    chk("pend_ready", cfg_ready, 0);
    cfg_valid = 0;
    rst = 1;
    tick();
    chk("rst2_outs", {clk_out, ce_rise, ce_fall, busy, cfg_err}, 5'b0);
    chk("rst2_pc", period_cnt, 0);
    chk("rst2_ready", cfg_ready, 1);
    rst = 0;
    for (int i = 0; i < 9; i++)
      st($sformatf("post_%0d", i), {(i % 4) < 2, (i % 4) == 0, (i % 4) == 2});
    chk("post_pc", period_cnt, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
